// File: rtl/tdm_demux_4t1_pkg.sv
// -----------------------------------------------------------------------------
// tdm_demux_4t1_pkg
// Shared constants for the 4-slot TDM multiplexer/demultiplexer pair.
//   - Slot indices (A..D) as used on the serial stream and by the slot counter.
//   - Demux frame-tracker state encodings.
//   - Modulo-4 slot increment helper.
// The same constants are used by the mux-side transmitter bench, so their
// values must not change.
// -----------------------------------------------------------------------------
package tdm_demux_4t1_pkg;

  typedef logic [1:0] slot_t;

  // Slot indices on the stream; slot A is the one flagged by the frame sync.
  localparam slot_t SLOT_A = 2'd0;
  localparam slot_t SLOT_B = 2'd1;
  localparam slot_t SLOT_C = 2'd2;
  localparam slot_t SLOT_D = 2'd3;

  localparam int NUM_SLOTS = 4;

  // Frame-tracker state encodings.
  localparam logic [0:0] ST_HUNT   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // Next slot in the frame; the 2-bit width gives the D -> A wrap for free.
  function automatic slot_t slot_inc(input slot_t s);
    return s + 2'd1;
  endfunction

endpackage

// File: rtl/tdm_demux_4t1_dec_2t4.sv
// -----------------------------------------------------------------------------
// dec_2t4
// Combinational 2-to-4 one-hot decoder with enable. Used by the demux to turn
// the effective slot of an accepted beat into per-channel write enables.
// Ports:
//   slot   [1:0]  slot index to decode
//   en            decode enable; all outputs 0 when low
//   onehot [3:0]  bit i set when en=1 and slot==i
// -----------------------------------------------------------------------------
module dec_2t4 (
  input  logic [1:0] slot,
  input  logic       en,
  output logic [3:0] onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dec
      assign onehot[gi] = en && (slot == 2'(gi));
    end
  endgenerate

endmodule

// File: rtl/tdm_demux_4t1.sv
// -----------------------------------------------------------------------------
// tdm_demux_4t1
// Receive side of the 4:1 TDM channel multiplexer. A single stream of beats is
// split back into four channel registers (A..D). A frame sync marks the slot-A
// beat; an internal 2-bit slot counter steers the following beats.
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   in_valid    beat present this cycle
//   in_sync     current beat is slot A (ignored when in_valid=0)
//   in_data     beat payload [DATA_W]
//   out_a..d    channel registers for slots 0..3 [DATA_W]
//   ch_valid    one-cycle strobe, bit i = channel i written on the last edge
//   sel         slot index of the last accepted beat
//   frame_done  one-cycle pulse after a slot-D beat is accepted
//   sync_err    one-cycle pulse on an early or (strict mode) missing sync
//   locked      1 while frame-locked
// Parameters:
//   DATA_W        beat / channel width
//   REQUIRE_SYNC  1: every slot-A beat must carry in_sync, otherwise drop lock
//                 0: the counter freewheels once locked
// -----------------------------------------------------------------------------
module tdm_demux_4t1
  import tdm_demux_4t1_pkg::*;
#(
  parameter int DATA_W       = 1,
  parameter bit REQUIRE_SYNC = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sync,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_c,
  output logic [DATA_W-1:0] out_d,
  output logic [3:0]        ch_valid,
  output logic [1:0]        sel,
  output logic              frame_done,
  output logic              sync_err,
  output logic              locked
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [0:0] state_reg, state_next;
  slot_t      cnt_reg, cnt_next;

  logic [3:0] ch_valid_reg;
  slot_t      sel_reg;
  logic       frame_done_reg;
  logic       sync_err_reg;
  logic       locked_reg;

  // ---------------------------------------------------------------------------
  // Beat classification
  // ---------------------------------------------------------------------------
  logic  is_locked;
  logic  cnt_at_a;
  logic  accept;
  logic  early_sync;
  logic  missing_sync;
  slot_t eff_slot;
  logic [3:0] wr_en;

  assign is_locked = (state_reg == ST_LOCKED);
  assign cnt_at_a  = (cnt_reg == SLOT_A);

  // A sync always restarts the frame at slot A, whatever the counter says.
  assign eff_slot = in_sync ? SLOT_A : cnt_reg;

  always_comb begin
    accept       = 1'b0;
    early_sync   = 1'b0;
    missing_sync = 1'b0;
    if (in_valid) begin
      if (!is_locked) begin
        // Hunting: only a sync beat is usable.
        accept = in_sync;
      end else if (in_sync) begin
        // Sync while locked is always accepted; mid-frame it realigns.
        accept     = 1'b1;
        early_sync = !cnt_at_a;
      end else if (!cnt_at_a) begin
        accept = 1'b1;
      end else if (REQUIRE_SYNC) begin
        // Slot A arrived without its sync: drop the beat and lose lock.
        missing_sync = 1'b1;
      end else begin
        // Freewheel mode: treat it as slot A.
        accept = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / counter
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (accept) begin
      state_next = ST_LOCKED;
      cnt_next   = slot_inc(eff_slot);
    end else if (missing_sync) begin
      state_next = ST_HUNT;
      cnt_next   = SLOT_A;
    end
  end

  // ---------------------------------------------------------------------------
  // Slot decoder -> channel write enables
  // ---------------------------------------------------------------------------
  dec_2t4 u_dec (
    .slot   (eff_slot),
    .en     (accept),
    .onehot (wr_en)
  );

  // ---------------------------------------------------------------------------
  // Channel registers
  // ---------------------------------------------------------------------------
  logic [NUM_SLOTS-1:0][DATA_W-1:0] ch_bus;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_ch
      logic [DATA_W-1:0] data_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          data_reg <= '0;
        end else if (wr_en[gi]) begin
          data_reg <= in_data;
        end
      end

      assign ch_bus[gi] = data_reg;
    end
  endgenerate

  assign out_a = ch_bus[SLOT_A];
  assign out_b = ch_bus[SLOT_B];
  assign out_c = ch_bus[SLOT_C];
  assign out_d = ch_bus[SLOT_D];

  // ---------------------------------------------------------------------------
  // Control and status registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_HUNT;
      cnt_reg        <= SLOT_A;
      ch_valid_reg   <= 4'b0000;
      sel_reg        <= SLOT_A;
      frame_done_reg <= 1'b0;
      sync_err_reg   <= 1'b0;
      locked_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      ch_valid_reg   <= wr_en;
      frame_done_reg <= accept && (eff_slot == SLOT_D);
      sync_err_reg   <= early_sync || missing_sync;
      locked_reg     <= (state_next == ST_LOCKED);
      // sel only follows accepted beats; drops and gaps leave it alone.
      if (accept) begin
        sel_reg <= eff_slot;
      end
    end
  end

  assign ch_valid   = ch_valid_reg;
  assign sel        = sel_reg;
  assign frame_done = frame_done_reg;
  assign sync_err   = sync_err_reg;
  assign locked     = locked_reg;

endmodule
